// File: rtl/alu_pkg.sv
// Shared ALU definitions: funct codes used by the ALU and its sequencer, plus sequencer FSM encoding.
package alu_pkg;

    localparam int unsigned FUNCT_W = 4;

    localparam logic [FUNCT_W-1:0] FN_ADD = 4'd0;
    localparam logic [FUNCT_W-1:0] FN_SUB = 4'd1;
    localparam logic [FUNCT_W-1:0] FN_AND = 4'd2;
    localparam logic [FUNCT_W-1:0] FN_OR  = 4'd3;
    localparam logic [FUNCT_W-1:0] FN_XOR = 4'd4;
    localparam logic [FUNCT_W-1:0] FN_NOT = 4'd5;
    localparam logic [FUNCT_W-1:0] FN_SLA = 4'd6;
    localparam logic [FUNCT_W-1:0] FN_SRA = 4'd7;
    localparam logic [FUNCT_W-1:0] FN_SRL = 4'd8;
    localparam logic [FUNCT_W-1:0] FN_MAX = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_SHIFT,
        ST_RESP
    } seq_state_t;

    // The ALU shifts by one bit per pass; these functs need iterating
    function automatic logic is_shift(input logic [FUNCT_W-1:0] funct);
        return (funct == FN_SLA) || (funct == FN_SRA) || (funct == FN_SRL);
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Drives an external combinational ALU for one request at a time; multi-bit shifts
// are decomposed into repeated 1-bit ALU shifts.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [FUNCT_W-1:0] req_funct,
    input  logic [DATA_W-1:0]  req_a,
    input  logic [DATA_W-1:0]  req_b,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [DATA_W-1:0]  resp_data,
    output logic               resp_zero,
    output logic               resp_err,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [FUNCT_W-1:0] alu_funct,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic               alu_zero
);

    seq_state_t         state, state_nxt;
    logic [SHAMT_W-1:0] cnt, cnt_nxt;
    logic               req_ready_nxt;
    logic               resp_valid_nxt;
    logic [DATA_W-1:0]  resp_data_nxt;
    logic               resp_zero_nxt;
    logic               resp_err_nxt;
    logic [DATA_W-1:0]  alu_a_nxt;
    logic [DATA_W-1:0]  alu_b_nxt;
    logic [FUNCT_W-1:0] alu_funct_nxt;
    logic               accept;
    logic [SHAMT_W-1:0] shamt;

    assign accept = req_valid & req_ready;
    assign shamt  = req_b[SHAMT_W-1:0];

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_zero  <= 1'b0;
            resp_err   <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_funct  <= FN_ADD;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            req_ready  <= req_ready_nxt;
            resp_valid <= resp_valid_nxt;
            resp_data  <= resp_data_nxt;
            resp_zero  <= resp_zero_nxt;
            resp_err   <= resp_err_nxt;
            alu_a      <= alu_a_nxt;
            alu_b      <= alu_b_nxt;
            alu_funct  <= alu_funct_nxt;
        end
    end

    // ALU port values are computed for the state being entered, so they are
    // already settled during EXEC/SHIFT and the result can be captured there.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        resp_valid_nxt = resp_valid;
        resp_data_nxt  = resp_data;
        resp_zero_nxt  = resp_zero;
        resp_err_nxt   = resp_err;
        alu_a_nxt      = '0;
        alu_b_nxt      = '0;
        alu_funct_nxt  = FN_ADD;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (req_funct > FN_MAX) begin
                        state_nxt     = ST_RESP;
                        resp_data_nxt = '0;
                        resp_zero_nxt = 1'b1;
                        resp_err_nxt  = 1'b1;
                    end else begin
                        resp_err_nxt = 1'b0;
                        if (is_shift(req_funct) && (shamt == '0)) begin
                            state_nxt     = ST_RESP;
                            resp_data_nxt = req_a;
                            resp_zero_nxt = (req_a == '0);
                        end else if (is_shift(req_funct)) begin
                            state_nxt     = ST_SHIFT;
                            cnt_nxt       = shamt;
                            alu_a_nxt     = req_a;
                            alu_b_nxt     = DATA_W'(1);
                            alu_funct_nxt = req_funct;
                        end else begin
                            state_nxt     = ST_EXEC;
                            alu_a_nxt     = req_a;
                            alu_b_nxt     = req_b;
                            alu_funct_nxt = req_funct;
                        end
                    end
                end
            end
            ST_EXEC: begin
                state_nxt     = ST_RESP;
                resp_data_nxt = alu_out;
                resp_zero_nxt = alu_zero;
            end
            ST_SHIFT: begin
                cnt_nxt = cnt - SHAMT_W'(1);
                if (cnt == SHAMT_W'(1)) begin
                    state_nxt     = ST_RESP;
                    resp_data_nxt = alu_out;
                    resp_zero_nxt = alu_zero;
                end else begin
                    alu_a_nxt     = alu_out;
                    alu_b_nxt     = DATA_W'(1);
                    alu_funct_nxt = alu_funct;
                end
            end
            ST_RESP: begin
                if (resp_valid && resp_ready) begin
                    resp_valid_nxt = 1'b0;
                    state_nxt      = ST_IDLE;
                end else begin
                    resp_valid_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt      = ST_IDLE;
                resp_valid_nxt = 1'b0;
            end
        endcase

        req_ready_nxt = (state_nxt == ST_IDLE);
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural ALU attached and a response scoreboard.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [3:0]        req_funct = 4'd0;
    logic [DATA_W-1:0] req_a = '0;
    logic [DATA_W-1:0] req_b = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic [DATA_W-1:0] resp_data;
    logic              resp_zero;
    logic              resp_err;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_funct;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zero;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              zero;
        logic              err;
        string             name;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   fails = 0;

    alu_op_sequencer #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct  (req_funct),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_zero  (resp_zero),
        .resp_err   (resp_err),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_funct  (alu_funct),
        .alu_out    (alu_out),
        .alu_zero   (alu_zero)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: shifts move by alu_b[0] only
    always_comb begin
        case (alu_funct)
            FN_ADD:  alu_out = alu_a + alu_b;
            FN_SUB:  alu_out = alu_a - alu_b;
            FN_AND:  alu_out = alu_a & alu_b;
            FN_OR:   alu_out = alu_a | alu_b;
            FN_XOR:  alu_out = alu_a ^ alu_b;
            FN_NOT:  alu_out = ~alu_a;
            FN_SLA:  alu_out = alu_a << alu_b[0];
            FN_SRA:  alu_out = DATA_W'($signed(alu_a) >>> alu_b[0]);
            FN_SRL:  alu_out = alu_a >> alu_b[0];
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == '0);
    end

    // Monitor: pops the scoreboard on each response handshake
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            vectors++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_resp: got data=%h zero=%b err=%b, required no response",
                         resp_data, resp_zero, resp_err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (resp_data !== e.data || resp_zero !== e.zero || resp_err !== e.err) begin
                    fails++;
                    $display("FAIL %s: got data=%h zero=%b err=%b, required data=%h zero=%b err=%b",
                             e.name, resp_data, resp_zero, resp_err, e.data, e.zero, e.err);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] req);
        vectors++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end
    endtask

    // mode 1: verify 1-bit ALU shift drive during SHIFT; mode 2: verify ALU left idle
    task automatic do_op(input string nm, input logic [3:0] f, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] ed,
                         input logic ez, input logic ee, input int el, input int mode, input int bp);
        int  lat;
        int  n;
        bit  got;
        exp_t e;
        resp_ready = (bp == 0);
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_req_ready"}, DATA_W'(req_ready), DATA_W'(1));
        req_valid = 1'b1;
        req_funct = f;
        req_a     = a;
        req_b     = b;
        e.data = ed; e.zero = ez; e.err = ee; e.name = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (resp_valid) begin
                got = 1'b1;
            end else if (mode == 1 && lat < el - 1) begin
                check({nm, "_shift_alu_b"}, alu_b, DATA_W'(1));
                check({nm, "_shift_funct"}, DATA_W'(alu_funct), DATA_W'(f));
            end
        end
        check({nm, "_latency"}, DATA_W'(lat), DATA_W'(el));
        if (mode == 2) begin
            check({nm, "_alu_idle_a"}, alu_a, '0);
            check({nm, "_alu_idle_funct"}, DATA_W'(alu_funct), DATA_W'(FN_ADD));
        end
        for (int i = 0; i < bp; i++) begin
            check({nm, "_bp_data"}, resp_data, ed);
            check({nm, "_bp_valid"}, DATA_W'(resp_valid), DATA_W'(1));
            check({nm, "_bp_req_ready"}, DATA_W'(req_ready), '0);
            @(negedge clk);
        end
        if (bp > 0) begin
            @(posedge clk);
            #1 resp_ready = 1'b1;
        end
        n = 0;
        while (resp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_drained"}, DATA_W'(sb.size()), '0);
    endtask

    initial begin
        bit spurious;
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit spurious;
        repeat (2) @(negedge clk);
        check("rst_req_ready", DATA_W'(req_ready), '0);
        check("rst_resp_valid", DATA_W'(resp_valid), '0);
        check("rst_resp_data", resp_data, '0);
        check("rst_alu_a", alu_a, '0);
        check("rst_alu_funct", DATA_W'(alu_funct), DATA_W'(FN_ADD));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rel_req_ready_before_clk", DATA_W'(req_ready), '0);
        @(negedge clk);
        check("rel_req_ready_after_clk", DATA_W'(req_ready), DATA_W'(1));

        do_op("add_5_7",    FN_ADD, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 2,  0, 0);
        do_op("sub_9_9",    FN_SUB, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0, 2,  0, 0);
        do_op("sra_4",      FN_SRA, 32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0, 1'b0, 5,  1, 0);
        do_op("sla_31",     FN_SLA, 32'd1,          32'd31,         32'h8000_0000,  1'b0, 1'b0, 32, 1, 0);
        do_op("srl_0",      FN_SRL, 32'hF0,         32'd0,          32'hF0,         1'b0, 1'b0, 1,  2, 0);
        do_op("sra_zero_0", FN_SRA, 32'd0,          32'd0,          32'd0,          1'b1, 1'b0, 1,  2, 0);
        do_op("illegal_c",  4'hC,   32'd3,          32'd4,          32'd0,          1'b1, 1'b1, 1,  0, 0);
        do_op("add_1_1",    FN_ADD, 32'd1,          32'd1,          32'd2,          1'b0, 1'b0, 2,  0, 0);
        do_op("and",        FN_AND, 32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0, 1'b0, 2,  0, 0);
        do_op("or",         FN_OR,  32'h10,         32'h01,         32'h11,         1'b0, 1'b0, 2,  0, 0);
        do_op("xor_self",   FN_XOR, 32'hA5A5_5A5A,  32'hA5A5_5A5A,  32'd0,          1'b1, 1'b0, 2,  0, 0);
        do_op("not_0",      FN_NOT, 32'd0,          32'h1234,       32'hFFFF_FFFF,  1'b0, 1'b0, 2,  0, 0);
        do_op("srl_hi_ign", FN_SRL, 32'h8000_0000,  32'h0000_0021,  32'h4000_0000,  1'b0, 1'b0, 2,  1, 0);
        do_op("add_wrap",   FN_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0, 2,  0, 0);
        do_op("bp_add",     FN_ADD, 32'd3,          32'd4,          32'd7,          1'b0, 1'b0, 2,  0, 3);

        // Abort a long shift with reset: no response may follow
        @(negedge clk);
        req_valid = 1'b1;
        req_funct = FN_SLA;
        req_a     = 32'd1;
        req_b     = 32'd20;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("midshift_alu_b_busy", alu_b, DATA_W'(1));
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", DATA_W'(req_ready), '0);
        check("midrst_resp_valid", DATA_W'(resp_valid), '0);
        check("midrst_resp_data", resp_data, '0);
        check("midrst_resp_err", DATA_W'(resp_err), '0);
        check("midrst_alu_a", alu_a, '0);
        check("midrst_alu_b", alu_b, '0);
        check("midrst_alu_funct", DATA_W'(alu_funct), DATA_W'(FN_ADD));
        @(posedge clk);
        #1 rst_n = 1'b1;
        spurious = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (resp_valid) spurious = 1'b1;
        end
        check("midrst_no_response", DATA_W'(spurious), '0);
        check("midrst_req_ready_back", DATA_W'(req_ready), DATA_W'(1));

        do_op("add_after_rst", FN_ADD, 32'd20, 32'd22, 32'd42, 1'b0, 1'b0, 2, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
